// File: rtl/ldst_ctrl.sv
// Load/store controller: sequences one memory op per request through IDLE/ACCESS/RESP.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module ldst_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_sext,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        ext_zextsext,
  output logic        ext_byteword,
  output logic [7:0]  ext_in,
  input  logic [15:0] ext_out,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          wr_q, wr_d;
  logic          byte_q, byte_d;
  logic          sext_q, sext_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rd_stb_q, rd_stb_d;
  logic          wr_stb_q, wr_stb_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DW-1:0] load_data;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = 4;
  // Count value seen in the 15th ACCESS cycle; no response there means timeout.
  localparam logic [TW-1:0] CNT_LAST = TW'(14);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          rsp_error_q, rsp_error_d;
`endif

  // Result selection for the completing access.
  assign load_data = wr_q ? DW'(0) : (byte_q ? ext_out : mem_rdata);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    wr_d        = wr_q;
    byte_d      = byte_q;
    sext_d      = sext_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_stb_d    = rd_stb_q;
    wr_stb_d    = wr_stb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_error_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d        = req_write;
          byte_d      = req_byte;
          sext_d      = req_sext;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          rd_stb_d    = !req_write;
          wr_stb_d    = req_write;
          req_ready_d = 1'b0;
          state_d     = S_ACCESS;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_ACCESS: begin
        if (mem_resp) begin
          rd_stb_d    = 1'b0;
          wr_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          state_d     = S_RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rd_stb_d    = 1'b0;
          wr_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
          cnt_d       = cnt_q + TW'(1);
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      S_RESP: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        rd_stb_d    = 1'b0;
        wr_stb_d    = 1'b0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      wr_q        <= wr_d;
      byte_q      <= byte_d;
      sext_q      <= sext_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_stb_q    <= rd_stb_d;
      wr_stb_q    <= wr_stb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

  // Memory-side fields are decoded straight from the latched op.
  assign req_ready       = req_ready_q;
  assign mem_read        = rd_stb_q;
  assign mem_write       = wr_stb_q;
  assign mem_address     = {addr_q[AW-1:1], 1'b0};
  assign mem_wdata       = byte_q ? {wdata_q[BW-1:0], wdata_q[BW-1:0]} : wdata_q;
  assign mem_byte_enable = byte_q ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
  assign ext_zextsext    = sext_q;
  assign ext_byteword    = 1'b0;
  assign ext_in          = addr_q[0] ? mem_rdata[DW-1:BW] : mem_rdata[BW-1:0];
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
`ifdef MEM_TIMEOUT_EN
  assign rsp_error       = rsp_error_q;
`else
  assign rsp_error       = 1'b0;
`endif

endmodule

// File: tb/tb_ldst_ctrl.sv
// Self-checking bench for ldst_ctrl: table of ops plus reset/ignore/timeout sequences.
module tb_ldst_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        req_write = 1'b0, req_byte = 1'b0, req_sext = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        ext_zextsext, ext_byteword;
  logic [7:0]  ext_in;
  logic [15:0] ext_out;
  logic        rsp_valid, rsp_error;
  logic [15:0] rsp_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  logic [16:0] exp_q[$];

  typedef struct {
    logic        write;
    logic        byte_op;
    logic        sext;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          delay;
    logic [15:0] exp_addr;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata;
    logic [7:0]  exp_ext;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  ldst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .ext_zextsext(ext_zextsext), .ext_byteword(ext_byteword),
    .ext_in(ext_in), .ext_out(ext_out),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  // Extension unit model.
  assign ext_out = ext_zextsext ? {{8{ext_in[7]}}, ext_in} : {8'h00, ext_in};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic w, input logic b, input logic s,
                              input logic [15:0] a, input logic [15:0] wd,
                              input logic [15:0] rd, input int dly,
                              input logic [15:0] ea, input logic [1:0] ebe,
                              input logic [15:0] ewd, input logic [7:0] eext,
                              input logic [15:0] erd);
    vec_t v;
    v.write = w; v.byte_op = b; v.sext = s; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.delay = dly; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd;
    v.exp_ext = eext; v.exp_rdata = erd;
    return v;
  endfunction

  // Called in the RESP cycle: pop one expected {error, rdata} and compare.
  task automatic sb_check(input string name);
    logic [16:0] e;
    chk({name, "_rsp_valid"}, rsp_valid, 1);
    chk({name, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, "_rsp"}, {rsp_error, rsp_rdata}, e);
    end
  endtask

  // Starts at a negedge with the DUT in IDLE; returns at the negedge after RESP.
  task automatic run_op(input string name, input vec_t v, input logic exp_err);
    chk({name, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_write = v.write; req_byte = v.byte_op; req_sext = v.sext;
    req_addr = v.addr; req_wdata = v.wdata;
    exp_q.push_back({exp_err, v.exp_rdata});
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~v.write; req_addr = 16'($urandom); req_wdata = 16'($urandom);
    chk({name, "_ext_sext"}, ext_zextsext, v.sext);
    chk({name, "_ext_byteword"}, ext_byteword, 0);
    for (int i = 0; i <= v.delay; i++) begin
      chk({name, "_mem_read"}, mem_read, !v.write);
      chk({name, "_mem_write"}, mem_write, v.write);
      chk({name, "_mem_address"}, mem_address, v.exp_addr);
      chk({name, "_byte_enable"}, mem_byte_enable, v.exp_be);
      chk({name, "_rsp_idle"}, rsp_valid, 0);
      if (v.write) chk({name, "_mem_wdata"}, mem_wdata, v.exp_wdata);
      if (i < v.delay) @(negedge clk);
    end
    mem_resp = 1'b1; mem_rdata = v.rdata;
    #1;
    if (v.byte_op && !v.write) chk({name, "_ext_in"}, ext_in, v.exp_ext);
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = 16'($urandom);
    sb_check(name);
    chk({name, "_strobes_resp"}, {mem_read, mem_write}, 0);
    chk({name, "_ready_resp"}, req_ready, 0);
    @(negedge clk);
    chk({name, "_rsp_pulse"}, rsp_valid, 0);
    chk({name, "_ready_back"}, req_ready, 1);
    chk({name, "_rdata_hold"}, rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    vec_t v;
    int n;
    //            w  b  s  addr      wdata     rdata     dly addr      be     wdata     ext    rdata
    vecs.push_back(mk(0, 0, 0, 16'h3001, 16'h0000, 16'hBEEF, 2, 16'h3000, 2'b11, 16'h0000, 8'h00, 16'hBEEF));
    vecs.push_back(mk(0, 1, 1, 16'h0005, 16'h0000, 16'h80FF, 1, 16'h0004, 2'b10, 16'h0000, 8'h80, 16'hFF80));
    vecs.push_back(mk(0, 1, 0, 16'h0005, 16'h0000, 16'h80FF, 0, 16'h0004, 2'b10, 16'h0000, 8'h80, 16'h0080));
    vecs.push_back(mk(1, 1, 0, 16'h0010, 16'h12AB, 16'h5A5A, 1, 16'h0010, 2'b01, 16'hABAB, 8'h00, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h2223, 16'hCAFE, 16'h9999, 0, 16'h2222, 2'b11, 16'hCAFE, 8'h00, 16'h0000));
    vecs.push_back(mk(0, 1, 1, 16'h0100, 16'h0000, 16'h1234, 3, 16'h0100, 2'b01, 16'h0000, 8'h34, 16'h0034));
    vecs.push_back(mk(0, 1, 1, 16'h0102, 16'h0000, 16'h00F0, 0, 16'h0102, 2'b01, 16'h0000, 8'hF0, 16'hFFF0));
    vecs.push_back(mk(1, 1, 1, 16'h7777, 16'hFF3C, 16'h0000, 2, 16'h7776, 2'b10, 16'h3C3C, 8'h00, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 16'hFFFE, 16'h0000, 16'h0001, 5, 16'hFFFE, 2'b11, 16'h0000, 8'h00, 16'h0001));

    // Reset state.
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table ops back-to-back: each starts in the cycle after the previous RESP.
    for (int i = 0; i < vecs.size(); i++) run_op($sformatf("vec%0d", i), vecs[i], 1'b0);

    // mem_resp while idle is ignored.
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("idle_resp_valid", rsp_valid, 0);
    chk("idle_resp_strobes", {mem_read, mem_write}, 0);
    chk("idle_resp_rdata", rsp_rdata, 16'h0001);

    // req_valid held through ACCESS and RESP is not latched.
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_sext = 1'b0;
    req_addr = 16'h4000; req_wdata = 16'h0000;
    exp_q.push_back({1'b0, 16'h1111});
    @(negedge clk);
    req_write = 1'b1; req_addr = 16'h5555; req_byte = 1'b1;
    chk("busy_ready", req_ready, 0);
    chk("busy_addr", mem_address, 16'h4000);
    chk("busy_strobes", {mem_read, mem_write}, 2'b10);
    mem_resp = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk);
    mem_resp = 1'b0;
    sb_check("busy");
    chk("busy_be", mem_byte_enable, 2'b11);
    req_valid = 1'b0;
    @(negedge clk);
    chk("busy_not_taken", {mem_read, mem_write, req_ready}, 3'b001);

    // Reset asserted in the second ACCESS cycle aborts the op.
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0A0A;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_access1", mem_read, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {mem_read, mem_write}, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_rdata", rsp_rdata, 0);
    mem_resp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_rsp", rsp_valid, 0);
    mem_resp = 1'b0;
    rst_n = 1'b1;
    run_op("post_rst", mk(0, 1, 1, 16'h0003, 16'h0000, 16'h7F00, 0, 16'h0002, 2'b10,
                          16'h0000, 8'h7F, 16'h007F), 1'b0);

`ifdef MEM_TIMEOUT_EN
    // Response in the 15th ACCESS cycle still wins over the timeout.
    run_op("resp_at_15", mk(0, 0, 0, 16'h0200, 16'h0000, 16'hA5A5, 14, 16'h0200, 2'b11,
                            16'h0000, 8'h00, 16'hA5A5), 1'b0);
    // No response at all: 15 ACCESS cycles then an error response.
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0300;
    exp_q.push_back({1'b1, 16'h0000});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (mem_read && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", n, 15);
    sb_check("timeout");
    @(negedge clk);
    chk("timeout_pulse", {rsp_valid, rsp_error}, 0);
    chk("timeout_ready", req_ready, 1);
`else
    // Without the watchdog a long wait still completes normally.
    run_op("long_wait", mk(0, 0, 0, 16'h0200, 16'h0000, 16'hA5A5, 20, 16'h0200, 2'b11,
                           16'h0000, 8'h00, 16'hA5A5), 1'b0);
    n = 0;
    chk("long_wait_err", rsp_error, n);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ldst_ctrl.md
LDST_CTRL -- requirements
Module: ldst_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
REQ-002 The request side SHALL have these ports.
- req_valid  in  1  pipeline presents a memory op.
- req_ready  out  1  controller can accept an op.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte op, 0 = word op.
- req_sext  in  1  byte load: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; low byte used for byte stores.
REQ-003 The memory side SHALL have these ports.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_address  out  16  word address.
- mem_wdata  out  16  write data.
- mem_byte_enable  out  2  lane enables.
- mem_resp  in  1  memory completion.
- mem_rdata  in  16  read data.
REQ-004 The extension-unit side SHALL have these ports.
- ext_zextsext  out  1  configures the extension unit: 0 = zero-extend, 1 = sign-extend.
- ext_byteword  out  1  configures the extension unit: 0 = byte, no shift.
- ext_in  out  8  selected byte lane.
- ext_out  in  16  extended result.
REQ-005 The response side SHALL have these ports.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  load result.
- rsp_error  out  1  access timed out.

Function
REQ-006 The FSM SHALL have three states: IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-007 On req_valid&&req_ready the block SHALL latch write, byte, sext, addr and wdata, and enter ACCESS next cycle.
REQ-008 In ACCESS the block SHALL drive mem_read=!write and mem_write=write from the latched op.
- mem_read and mem_write SHALL be held constant until mem_resp.
- mem_address SHALL be {addr[15:1],1'b0}.
REQ-009 mem_byte_enable SHALL be set as follows.
- Word op: 2'b11.
- Byte op with addr[0]=0: 2'b01.
- Byte op with addr[0]=1: 2'b10.
REQ-010 mem_wdata SHALL be the full 16-bit wdata for word ops and {wdata[7:0],wdata[7:0]} for byte ops.
REQ-011 The extension-unit outputs SHALL be driven as follows.
- ext_in = addr[0] ? mem_rdata[15:8] : mem_rdata[7:0].
- ext_zextsext = latched sext.
- ext_byteword = 0.
REQ-012 When mem_resp=1 in ACCESS, the block SHALL capture the result on that edge and go to RESP.
- Byte load: capture ext_out.
- Word load: capture mem_rdata.
- Store: capture 16'h0000.
REQ-013 RESP SHALL last exactly one cycle with rsp_valid=1 and rsp_rdata=captured value, then return to IDLE.
REQ-014 Minimum latency SHALL be 3 cycles from accept to rsp_valid (accept, ACCESS with mem_resp, RESP); back-to-back accept SHALL be possible in the cycle after RESP.
REQ-015 mem_resp outside ACCESS SHALL be ignored; req_valid outside IDLE SHALL be ignored with no latching.
REQ-016 Strobes SHALL be 0 in IDLE and RESP; rsp_rdata SHALL hold its last value outside RESP.

Reset
REQ-017 While rst_n=0, the block SHALL force the following immediately and asynchronously.
- State = IDLE.
- mem_read, mem_write, rsp_valid, rsp_error = 0.
- rsp_rdata, latched op = 0.
REQ-018 Reset during ACCESS SHALL abort the access with no rsp_valid; the first accept SHALL be possible in the first clock after rst_n rises.

Configuration
REQ-019 With MEM_TIMEOUT_EN defined, a 4-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_resp.
- On reaching 15, the block SHALL drop strobes and go to RESP with rsp_error=1 and rsp_rdata=16'h0000.
- A mem_resp arriving in the same cycle as the count reaching 15 SHALL win: normal completion, rsp_error=0.
REQ-020 Without MEM_TIMEOUT_EN, ACCESS SHALL wait indefinitely for mem_resp, and rsp_error SHALL be tied to 0.

Verification
REQ-021 Word load, addr=16'h3001, mem_rdata=16'hBEEF, mem_resp after 2 cycles -> mem_address=16'h3000, byte_enable=2'b11, rsp_rdata=16'hBEEF, rsp_valid one cycle.
REQ-022 Byte load sext=1, addr=16'h0005, mem_rdata=16'h80FF -> ext_in=8'h80, rsp_rdata=16'hFF80; same with sext=0 -> rsp_rdata=16'h0080.
REQ-023 Byte store addr=16'h0010, wdata=16'h12AB -> mem_write=1, mem_wdata=16'hABAB, byte_enable=2'b01, rsp_rdata=0.
REQ-024 rst_n pulled low in 2nd ACCESS cycle -> strobes 0 same cycle, no rsp_valid, and a new request is accepted on the first edge after release.
REQ-025 MEM_TIMEOUT_EN defined, mem_resp never asserted -> 15 ACCESS cycles, then rsp_valid=1, rsp_error=1, rsp_rdata=0, then back to IDLE.
